time_gen: RTL and testbench

//  BCD time-of-day source for the alarm clock. Holds the running HH:MM:SS count and the alarm setpoint.

---
 rtl/time_gen_if.sv | 23 ++
 rtl/time_gen.sv | 118 +++++++++++
 tb/tb_time_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/time_gen_if.sv
// time_gen_if: set strobes from the UI side and time/alarm/tick outputs toward the display side.
interface time_gen_if;
  logic        load_time;
  logic        load_alarm;
  logic [15:0] set_value;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic [7:0]  seconds;
  logic        sec_tick;
  logic        min_tick;
  logic        load_err;
  logic        alarm_match;

  modport master (
    output load_time, load_alarm, set_value,
    input  current_time, alarm_time, seconds, sec_tick, min_tick, load_err, alarm_match
  );

  modport slave (
    input  load_time, load_alarm, set_value,
    output current_time, alarm_time, seconds, sec_tick, min_tick, load_err, alarm_match
  );
endinterface

// File: rtl/time_gen.sv
// time_gen: BCD HH:MM:SS time-of-day counter with validated set strobes, alarm setpoint and tick pulses.
// Optional feature macro ALARM_MATCH_EN builds the alarm comparator; otherwise alarm_match is tied low.
module time_gen #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic      clk,
  input  logic      reset,
  time_gen_if.slave bus
);
  localparam int unsigned   PW         = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic [15:0]   time_q;
  logic [15:0]   alarm_q;
  logic [7:0]    sec_q;
  logic          sec_tick_q;
  logic          min_tick_q;
  logic          load_err_q;

  logic          set_ok;
  logic          load_time_ok;
  logic          load_alarm_ok;
  logic          load_bad;
  logic          presc_wrap;
  logic          sec_wrap;
  logic          min_wrap;
  logic [7:0]    sec_inc;
  logic [7:0]    min_inc;
  logic [7:0]    hr_inc;
  logic [15:0]   time_inc;
  logic [15:0]   alarm_next;

  // Two-digit BCD increment that rolls to 00 after 'last'; never exposes a non-BCD digit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[15:12] <= 4'd2) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9)
           && !((v[15:12] == 4'd2) && (v[11:8] > 4'd3));
  endfunction

  always_comb begin
    set_ok        = bcd_valid(bus.set_value);
    load_time_ok  = bus.load_time & set_ok;
    load_alarm_ok = bus.load_alarm & set_ok;
    load_bad      = (bus.load_time | bus.load_alarm) & ~set_ok;
    presc_wrap    = (presc == PRESC_LAST);
    sec_wrap      = (sec_q == 8'h59);
    min_wrap      = (time_q[7:0] == 8'h59);
    sec_inc       = bcd_inc(sec_q, 8'h59);
    min_inc       = bcd_inc(time_q[7:0], 8'h59);
    hr_inc        = bcd_inc(time_q[15:8], 8'h23);
    time_inc      = {min_wrap ? hr_inc : time_q[15:8], min_inc};
    alarm_next    = load_alarm_ok ? bus.set_value : alarm_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      time_q     <= '0;
      alarm_q    <= '0;
      sec_q      <= '0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      load_err_q <= load_bad;
      alarm_q    <= alarm_next;
      // A valid time load overrides a coincident prescaler wrap, suppressing its ticks.
      if (load_time_ok) begin
        time_q <= bus.set_value;
        sec_q  <= '0;
        presc  <= '0;
      end else if (presc_wrap) begin
        presc      <= '0;
        sec_q      <= sec_inc;
        sec_tick_q <= 1'b1;
        if (sec_wrap) begin
          min_tick_q <= 1'b1;
          time_q     <= time_inc;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

`ifdef ALARM_MATCH_EN
  logic match_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      match_q <= 1'b0;
    else
      match_q <= !load_time_ok && presc_wrap && sec_wrap && (time_inc == alarm_next);
  end

  assign bus.alarm_match = match_q;
`else
  assign bus.alarm_match = 1'b0;
`endif

  assign bus.current_time = time_q;
  assign bus.alarm_time   = alarm_q;
  assign bus.seconds      = sec_q;
  assign bus.sec_tick     = sec_tick_q;
  assign bus.min_tick     = min_tick_q;
  assign bus.load_err     = load_err_q;
endmodule

// File: tb/tb_time_gen.sv
// tb_time_gen: table vectors plus hand sequences for time_gen with TICKS_PER_SEC=4; expectations go
// through a scoreboard queue and are popped when the DUT output for that cycle is sampled.
module tb_time_gen;
  logic clk = 1'b0;
  logic reset = 1'b0;

  time_gen_if bus();

  time_gen #(.TICKS_PER_SEC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef ALARM_MATCH_EN
  localparam logic AM = 1'b1;
`else
  localparam logic AM = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] cur;
    logic [15:0] alarm;
    logic [7:0]  sec;
    logic        st;
    logic        mt;
    logic        err;
    logic        am;
  } exp_t;

  typedef struct {
    string       name;
    logic        lt;
    logic        la;
    logic [15:0] sv;
    logic [15:0] cur;
    logic [15:0] alarm;
    logic [7:0]  sec;
    logic        st;
    logic        err;
  } vec_t;

  exp_t sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic push_exp(input string name, input logic [15:0] cur, input logic [15:0] alarm,
                          input logic [7:0] sec, input logic st, input logic mt, input logic err,
                          input logic am);
    exp_t e;
    e.name = name; e.cur = cur; e.alarm = alarm; e.sec = sec;
    e.st = st; e.mt = mt; e.err = err; e.am = am;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got an output sample with no expectation queued");
      return;
    end
    e = sb.pop_front();
    if (bus.current_time !== e.cur || bus.alarm_time !== e.alarm || bus.seconds !== e.sec ||
        bus.sec_tick !== e.st || bus.min_tick !== e.mt || bus.load_err !== e.err ||
        bus.alarm_match !== e.am) begin
      miscompares++;
      $display("FAIL %s: got cur=%h al=%h sec=%h st=%b mt=%b err=%b am=%b, want cur=%h al=%h sec=%h st=%b mt=%b err=%b am=%b",
               e.name, bus.current_time, bus.alarm_time, bus.seconds, bus.sec_tick, bus.min_tick,
               bus.load_err, bus.alarm_match, e.cur, e.alarm, e.sec, e.st, e.mt, e.err, e.am);
    end
  endtask

  task automatic chk_int(input string name, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic lt, input logic la, input logic [15:0] sv);
    bus.load_time  = lt;
    bus.load_alarm = la;
    bus.set_value  = sv;
  endtask

  // Called at a negedge: drive, queue the expectation, cross one rising edge, sample at the next negedge.
  task automatic step(input string name, input logic lt, input logic la, input logic [15:0] sv,
                      input logic [15:0] cur, input logic [15:0] alarm, input logic [7:0] sec,
                      input logic st, input logic mt, input logic err, input logic am);
    drive(lt, la, sv);
    push_exp(name, cur, alarm, sec, st, mt, err, am);
    @(posedge clk);
    @(negedge clk);
    check_pop();
  endtask

  task automatic idle(input int unsigned n);
    drive(1'b0, 1'b0, 16'h0000);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_until_min(input int unsigned budget, output int unsigned n,
                               output int unsigned ticks);
    n = 0;
    ticks = 0;
    drive(1'b0, 1'b0, 16'h0000);
    for (int unsigned i = 1; i <= budget; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.sec_tick) ticks++;
      if (bus.min_tick) begin
        n = i;
        break;
      end
    end
  endtask

  vec_t tbl[19];
  int unsigned n_cyc;
  int unsigned n_st;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 16'h0000);

    tbl[0]  = '{"run_c1",      0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0, 0};
    tbl[1]  = '{"run_c2",      0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0, 0};
    tbl[2]  = '{"run_c3",      0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0, 0};
    tbl[3]  = '{"run_sec01",   0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h01, 1, 0};
    tbl[4]  = '{"run_c5",      0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h01, 0, 0};
    tbl[5]  = '{"run_c6",      0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h01, 0, 0};
    tbl[6]  = '{"run_c7",      0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h01, 0, 0};
    tbl[7]  = '{"run_sec02",   0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h02, 1, 0};
    tbl[8]  = '{"bad_lt_2400", 1, 0, 16'h2400, 16'h0000, 16'h0000, 8'h02, 0, 1};
    tbl[9]  = '{"bad_la_0060", 0, 1, 16'h0060, 16'h0000, 16'h0000, 8'h02, 0, 1};
    tbl[10] = '{"bad_lt_1a00", 1, 0, 16'h1A00, 16'h0000, 16'h0000, 8'h02, 0, 1};
    tbl[11] = '{"bad_la_2400", 0, 1, 16'h2400, 16'h0000, 16'h0000, 8'h03, 1, 1};
    tbl[12] = '{"bad_lt_0060", 1, 0, 16'h0060, 16'h0000, 16'h0000, 8'h03, 0, 1};
    tbl[13] = '{"bad_la_1a00", 0, 1, 16'h1A00, 16'h0000, 16'h0000, 8'h03, 0, 1};
    tbl[14] = '{"err_clear",   0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h03, 0, 0};
    tbl[15] = '{"run_sec04",   0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h04, 1, 0};
    tbl[16] = '{"la_1234",     0, 1, 16'h1234, 16'h0000, 16'h1234, 8'h04, 0, 0};
    tbl[17] = '{"idle_a",      0, 0, 16'h0000, 16'h0000, 16'h1234, 8'h04, 0, 0};
    tbl[18] = '{"both_2358",   1, 1, 16'h2358, 16'h2358, 16'h2358, 8'h00, 0, 0};

    #12;
    push_exp("reset_state", 16'h0000, 16'h0000, 8'h00, 0, 0, 0, 0);
    check_pop();
    @(negedge clk);
    reset = 1'b1;

    for (int unsigned i = 0; i < 19; i++)
      step(tbl[i].name, tbl[i].lt, tbl[i].la, tbl[i].sv, tbl[i].cur, tbl[i].alarm, tbl[i].sec,
           tbl[i].st, 1'b0, tbl[i].err, 1'b0);

    // Day wrap 23:59:59 -> 00:00:00
    step("load_2359", 1, 0, 16'h2359, 16'h2359, 16'h2358, 8'h00, 0, 0, 0, 0);
    run_until_min(300, n_cyc, n_st);
    chk_int("wrap_2359_cycles", n_cyc, 240);
    chk_int("wrap_2359_sec_ticks", n_st, 60);
    push_exp("wrap_2359", 16'h0000, 16'h2358, 8'h00, 1, 1, 0, 0);
    check_pop();
    step("after_wrap", 0, 0, 16'h0000, 16'h0000, 16'h2358, 8'h00, 0, 0, 0, 0);

    // BCD carries across digit boundaries
    step("load_0959", 1, 0, 16'h0959, 16'h0959, 16'h2358, 8'h00, 0, 0, 0, 0);
    run_until_min(300, n_cyc, n_st);
    chk_int("carry_0959_cycles", n_cyc, 240);
    push_exp("carry_0959", 16'h1000, 16'h2358, 8'h00, 1, 1, 0, 0);
    check_pop();
    step("load_1959", 1, 0, 16'h1959, 16'h1959, 16'h2358, 8'h00, 0, 0, 0, 0);
    run_until_min(300, n_cyc, n_st);
    chk_int("carry_1959_cycles", n_cyc, 240);
    push_exp("carry_1959", 16'h2000, 16'h2358, 8'h00, 1, 1, 0, 0);
    check_pop();

    // Load in the prescaler wrap cycle
    step("load_0000", 1, 0, 16'h0000, 16'h0000, 16'h2358, 8'h00, 0, 0, 0, 0);
    step("pre_p1", 0, 0, 16'h0000, 16'h0000, 16'h2358, 8'h00, 0, 0, 0, 0);
    step("pre_p2", 0, 0, 16'h0000, 16'h0000, 16'h2358, 8'h00, 0, 0, 0, 0);
    step("pre_p3", 0, 0, 16'h0000, 16'h0000, 16'h2358, 8'h00, 0, 0, 0, 0);
    step("load_at_wrap", 1, 0, 16'h0815, 16'h0815, 16'h2358, 8'h00, 0, 0, 0, 0);
    step("post_1", 0, 0, 16'h0000, 16'h0815, 16'h2358, 8'h00, 0, 0, 0, 0);
    step("post_2", 0, 0, 16'h0000, 16'h0815, 16'h2358, 8'h00, 0, 0, 0, 0);
    step("post_3", 0, 0, 16'h0000, 16'h0815, 16'h2358, 8'h00, 0, 0, 0, 0);
    step("post_tick", 0, 0, 16'h0000, 16'h0815, 16'h2358, 8'h01, 1, 0, 0, 0);

    // Held load_time freezes the count
    for (int unsigned i = 0; i < 6; i++)
      step("held_load", 1, 0, 16'h1111, 16'h1111, 16'h2358, 8'h00, 0, 0, 0, 0);

    // Alarm match on the minute tick only, never on a load
    step("la_0001", 0, 1, 16'h0001, 16'h1111, 16'h0001, 8'h00, 0, 0, 0, 0);
    step("lt_eq_alarm", 1, 0, 16'h0001, 16'h0001, 16'h0001, 8'h00, 0, 0, 0, 0);
    step("lt_0000", 1, 0, 16'h0000, 16'h0000, 16'h0001, 8'h00, 0, 0, 0, 0);
    run_until_min(300, n_cyc, n_st);
    chk_int("alarm_cycles", n_cyc, 240);
    push_exp("alarm_hit", 16'h0001, 16'h0001, 8'h00, 1, 1, 0, AM);
    check_pop();
    step("alarm_clear", 0, 0, 16'h0000, 16'h0001, 16'h0001, 8'h00, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a count
    idle(5);
    #2;
    reset = 1'b0;
    #1;
    push_exp("async_reset", 16'h0000, 16'h0000, 8'h00, 0, 0, 0, 0);
    check_pop();
    @(posedge clk);
    @(negedge clk);
    push_exp("reset_held", 16'h0000, 16'h0000, 8'h00, 0, 0, 0, 0);
    check_pop();
    reset = 1'b1;
    step("rel_1", 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0, 0, 0, 0);
    step("rel_2", 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0, 0, 0, 0);
    step("rel_3", 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 0, 0, 0, 0);
    step("rel_tick", 0, 0, 16'h0000, 16'h0000, 16'h0000, 8'h01, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
